// File: rtl/bresenham_stepper.sv
// Bresenham ray stepper. It folds a signed endpoint offset into the first octant,
// then streams normalised (x_in, y_in) points with the flags the flip stage needs.
module bresenham_stepper #(
  parameter int XW = 8,
  parameter int YW = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic signed [XW-1:0] dx,
  input  logic signed [YW-1:0] dy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XW-1:0]        x_in,
  output logic [YW-1:0]        y_in,
  output logic                 flip_x,
  output logic                 flip_y,
  output logic                 flip_identity,
  output logic                 last
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_STEP  = 2'd2
  } state_t;

  // Most negative inputs are pulled in by one so every magnitude fits XW-1 / YW-1 bits.
  localparam logic signed [XW-1:0] DX_MIN = {1'b1, {(XW-1){1'b0}}};
  localparam logic signed [XW-1:0] DX_SAT = {1'b1, {(XW-2){1'b0}}, 1'b1};
  localparam logic signed [YW-1:0] DY_MIN = {1'b1, {(YW-1){1'b0}}};
  localparam logic signed [YW-1:0] DY_SAT = {1'b1, {(YW-2){1'b0}}, 1'b1};
  localparam logic [XW-1:0]        X_ONE  = {{(XW-1){1'b0}}, 1'b1};
  localparam logic [YW-1:0]        Y_ONE  = {{(YW-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic signed [XW-1:0]  dx_q, dx_d;
  logic signed [YW-1:0]  dy_q, dy_d;
  logic [XW-1:0]         major_q, major_d;
  logic [XW-1:0]         minor_q, minor_d;
  logic signed [XW+1:0]  err_q, err_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic                  fx_q, fx_d;
  logic                  fy_q, fy_d;
  logic                  fi_q, fi_d;
  logic                  last_q, last_d;

  // Octant classification of the captured command
  logic signed [XW-1:0]  dx_sat;
  logic signed [YW-1:0]  dy_sat;
  logic [XW-1:0]         ax;
  logic [YW-1:0]         ay;
  logic [XW-1:0]         ay_ext;
  logic                  swap;
  logic [XW-1:0]         major_s;
  logic [XW-1:0]         minor_s;
  logic signed [XW+1:0]  err_init;

  always_comb begin
    dx_sat   = (dx_q == DX_MIN) ? DX_SAT : dx_q;
    dy_sat   = (dy_q == DY_MIN) ? DY_SAT : dy_q;
    ax       = dx_sat[XW-1] ? -dx_sat : dx_sat;
    ay       = dy_sat[YW-1] ? -dy_sat : dy_sat;
    ay_ext   = {{(XW-YW){1'b0}}, ay};
    swap     = (ay_ext > ax);
    major_s  = swap ? ay_ext : ax;
    minor_s  = swap ? ax : ay_ext;
    err_init = $signed({1'b0, minor_s, 1'b0}) - $signed({2'b00, major_s});
  end

  // Stepping arithmetic for the point currently presented
  logic [XW-1:0]         x_inc;
  logic                  err_pos;
  logic signed [XW+1:0]  err_diag;
  logic signed [XW+1:0]  err_flat;

  always_comb begin
    x_inc    = x_q + X_ONE;
    err_pos  = !err_q[XW+1] && (err_q != '0);
    err_flat = err_q + $signed({1'b0, minor_q, 1'b0});
    err_diag = err_flat - $signed({1'b0, major_q, 1'b0});
  end

  always_comb begin
    state_d = state_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    major_d = major_q;
    minor_d = minor_q;
    err_d   = err_q;
    x_d     = x_q;
    y_d     = y_q;
    fx_d    = fx_q;
    fy_d    = fy_q;
    fi_d    = fi_q;
    last_d  = last_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          dx_d    = dx;
          dy_d    = dy;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        fx_d    = dx_sat[XW-1];
        fy_d    = dy_sat[YW-1];
        fi_d    = swap;
        major_d = major_s;
        minor_d = minor_s;
        err_d   = err_init;
        x_d     = '0;
        y_d     = '0;
        last_d  = (major_s == '0);
        state_d = S_STEP;
      end

      S_STEP: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = S_IDLE;
          end else begin
            x_d    = x_inc;
            last_d = (x_inc == major_q);
            if (err_pos) begin
              y_d   = y_q + Y_ONE;
              err_d = err_diag;
            end else begin
              err_d = err_flat;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dx_q    <= '0;
      dy_q    <= '0;
      major_q <= '0;
      minor_q <= '0;
      err_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      fx_q    <= 1'b0;
      fy_q    <= 1'b0;
      fi_q    <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      major_q <= major_d;
      minor_q <= minor_d;
      err_q   <= err_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      fi_q    <= fi_d;
      last_q  <= last_d;
    end
  end

  assign cmd_ready     = (state_q == S_IDLE);
  assign out_valid     = (state_q == S_STEP);
  assign x_in          = x_q;
  assign y_in          = y_q;
  assign flip_x        = fx_q;
  assign flip_y        = fy_q;
  assign flip_identity = fi_q;
  assign last          = last_q;

endmodule

// File: tb/tb_bresenham_stepper.sv
// Bench for bresenham_stepper: a table of rays checked against a closed-form line model
// through a point scoreboard, plus latency, backpressure, junk-command and reset sequences.
module tb_bresenham_stepper;

  localparam int XW = 8;
  localparam int YW = 7;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic signed [XW-1:0] dx;
  logic signed [YW-1:0] dy;
  logic                 out_valid;
  logic                 out_ready;
  logic [XW-1:0]        x_in;
  logic [YW-1:0]        y_in;
  logic                 flip_x;
  logic                 flip_y;
  logic                 flip_identity;
  logic                 last;

  bresenham_stepper #(.XW(XW), .YW(YW)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .dx            (dx),
    .dy            (dy),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .x_in          (x_in),
    .y_in          (y_in),
    .flip_x        (flip_x),
    .flip_y        (flip_y),
    .flip_identity (flip_identity),
    .last          (last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    bit fx;
    bit fy;
    bit fi;
    bit last;
  } pt_t;

  typedef struct {
    int dx;
    int dy;
    bit fx;
    bit fy;
    bit fi;
    int n;
    int ex;
    int ey;
  } vec_t;

  pt_t  sbq[$];
  vec_t tbl[11];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_point(input string name, input pt_t e);
    n_assert++;
    if (int'(x_in) !== e.x || int'(y_in) !== e.y || flip_x !== e.fx || flip_y !== e.fy ||
        flip_identity !== e.fi || last !== e.last) begin
      n_fail++;
      $display("FAIL %s: got (%0d,%0d) flags=%b%b%b last=%b, expected (%0d,%0d) flags=%b%b%b last=%b",
               name, x_in, y_in, flip_x, flip_y, flip_identity, last,
               e.x, e.y, e.fx, e.fy, e.fi, e.last);
    end
  endtask

  // Model: first-octant Bresenham with "step when err > 0" is y = round-half-down(minor*x/major).
  task automatic push_ray(input int dxv, input int dyv);
    int  sx, sy, ax, ay, mj, mn;
    bit  fi;
    pt_t p;
    sx = (dxv < -127) ? -127 : dxv;
    sy = (dyv < -63) ? -63 : dyv;
    ax = (sx < 0) ? -sx : sx;
    ay = (sy < 0) ? -sy : sy;
    fi = (ay > ax);
    mj = fi ? ay : ax;
    mn = fi ? ax : ay;
    for (int x = 0; x <= mj; x++) begin
      p.x    = x;
      p.y    = (mj == 0) ? 0 : (2 * mn * x + mj - 1) / (2 * mj);
      p.fx   = (dxv < 0);
      p.fy   = (dyv < 0);
      p.fi   = fi;
      p.last = (x == mj);
      sbq.push_back(p);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sbq.delete();
  endtask

  // Called at a sample point (1 time unit after a rising edge) with the DUT idle.
  task automatic run_ray(input int dxv, input int dyv, input int stall_at, input int stall_len,
                         input bit junk, input int abort_at, output int npts, output pt_t lp);
    int  lat, guard, stalls;
    bit  done, broken;
    pt_t e;
    npts   = 0;
    stalls = 0;
    done   = 1'b0;
    broken = 1'b0;
    guard  = 0;
    lp     = '{default: 0};
    check("cmd_ready_idle", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    dx        = dxv[XW-1:0];
    dy        = dyv[YW-1:0];
    out_ready = 1'b1;
    push_ray(dxv, dyv);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        cmd_valid = junk;
        dx = XW'($urandom);
        dy = YW'($urandom);
        check("cmd_ready_setup", int'(cmd_ready), 0);
        check("out_valid_setup", int'(out_valid), 0);
      end
    end while (!out_valid && lat < 10);
    check("first_point_latency", lat, 2);

    while (!done && guard < 1000) begin
      guard++;
      if (junk) begin
        dx = XW'($urandom);
        dy = YW'($urandom);
      end
      if (!out_valid) begin
        check("out_valid_mid_ray", int'(out_valid), 1);
        broken = 1'b1;
        done   = 1'b1;
      end else if (npts == abort_at) begin
        rst = 1'b1;
        #1;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_cmd_ready", int'(cmd_ready), 1);
        check("abort_x_in", int'(x_in), 0);
        broken = 1'b1;
        done   = 1'b1;
      end else if (sbq.size() == 0) begin
        check("extra_point_x", int'(x_in), -1);
        broken = 1'b1;
        done   = 1'b1;
      end else if (npts == stall_at && stalls < stall_len) begin
        out_ready = 1'b0;
        cmp_point("stall_hold", sbq[0]);
        stalls++;
      end else begin
        out_ready = 1'b1;
        e = sbq.pop_front();
        cmp_point($sformatf("point%0d", npts), e);
        npts++;
        lp.x = int'(x_in);
        lp.y = int'(y_in);
        lp.fx = flip_x;
        lp.fy = flip_y;
        lp.fi = flip_identity;
        lp.last = last;
        if (last) begin
          cmd_valid = 1'b0;
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end

    if (!done) begin
      check("ray_cycle_budget", guard, -1);
      broken = 1'b1;
    end
    if (broken) begin
      pulse_reset();
    end else begin
      check("cmd_ready_after_last", int'(cmd_ready), 1);
      check("out_valid_after_last", int'(out_valid), 0);
      check("scoreboard_empty", sbq.size(), 0);
    end
    $display("ray dx=%0d dy=%0d points=%0d end=(%0d,%0d) flags=%b%b%b", dxv, dyv, npts,
             lp.x, lp.y, lp.fx, lp.fy, lp.fi);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    pt_t lp;

    //          dx    dy  fx fy fi    n   ex   ey
    tbl[0]  = '{   5,   2, 0, 0, 0,   6,   5,   2};
    tbl[1]  = '{  -3,   7, 1, 0, 1,   8,   7,   3};
    tbl[2]  = '{   4,  -4, 0, 1, 0,   5,   4,   4};
    tbl[3]  = '{   0,   0, 0, 0, 0,   1,   0,   0};
    tbl[4]  = '{-128,   0, 1, 0, 0, 128, 127,   0};
    tbl[5]  = '{-128, -64, 1, 1, 0, 128, 127,  63};
    tbl[6]  = '{  10, -64, 0, 1, 1,  64,  63,  10};
    tbl[7]  = '{   0,  -5, 0, 1, 1,   6,   5,   0};
    tbl[8]  = '{  -7,  -2, 1, 1, 0,   8,   7,   2};
    tbl[9]  = '{ 127,  63, 0, 0, 0, 128, 127,  63};
    tbl[10] = '{   1,   1, 0, 0, 0,   2,   1,   1};

    rst       = 1'b1;
    cmd_valid = 1'b0;
    dx        = '0;
    dy        = '0;
    out_ready = 1'b1;
    #2;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_cmd_ready", int'(cmd_ready), 1);
    check("reset_x_in", int'(x_in), 0);
    check("reset_y_in", int'(y_in), 0);
    check("reset_flags", int'({flip_x, flip_y, flip_identity}), 0);
    check("reset_last", int'(last), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      run_ray(tbl[i].dx, tbl[i].dy, -1, 0, 1'b0, -1, n, lp);
      check($sformatf("vec%0d_count", i), n, tbl[i].n);
      check($sformatf("vec%0d_end_x", i), lp.x, tbl[i].ex);
      check($sformatf("vec%0d_end_y", i), lp.y, tbl[i].ey);
      check($sformatf("vec%0d_flags", i), int'({lp.fx, lp.fy, lp.fi}),
            int'({tbl[i].fx, tbl[i].fy, tbl[i].fi}));
    end

    // Backpressure: hold (2,1) for three cycles, then resume at (3,1).
    run_ray(5, 2, 2, 3, 1'b0, -1, n, lp);
    check("bp_count", n, 6);
    check("bp_end_y", lp.y, 2);

    // Commands offered while busy, with dx/dy churning, must not disturb the ray.
    run_ray(-7, -2, -1, 0, 1'b1, -1, n, lp);
    check("junk_count", n, 8);
    check("junk_end_x", lp.x, 7);

    // Asynchronous reset at point 40 of a saturated ray, then a clean short ray.
    run_ray(-128, 0, -1, 0, 1'b0, 40, n, lp);
    check("abort_points_before_reset", n, 40);
    run_ray(1, 1, -1, 0, 1'b0, -1, n, lp);
    check("post_reset_count", n, 2);
    check("post_reset_end", int'({lp.x[7:0], lp.y[7:0]}), int'({8'd1, 8'd1}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bresenham_stepper.md
Name: bresenham_stepper

Overview:
- Upstream neighbour of the index-flipping stage in the Bresenham ray tracer of the Hector SLAM map-update path.
- Accepts one ray per command as a signed endpoint offset (dx, dy) from the ray origin.
- Classifies the ray's octant and iterates Bresenham in normalised first-octant space (x major, 0 ≤ y ≤ x).
- Streams normalised points plus the flip_x / flip_y / flip_identity flags that the flip stage uses to restore real map offsets.

Parameters:
- XW, 8, width of dx and of the normalised major coordinate x_in.
- YW, 7, width of dy and of the normalised minor coordinate y_in.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- cmd_valid  input  1  command offer.
- cmd_ready  output  1  block can accept a command; high only in IDLE.
- dx  input  XW  signed x offset of the ray endpoint.
- dy  input  YW  signed y offset of the ray endpoint.
- out_valid  output  1  a point is presented.
- out_ready  input  1  consumer accepts the point.
- x_in  output  XW  normalised major coordinate, 0..major.
- y_in  output  YW  normalised minor coordinate, 0..minor.
- flip_x  output  1  dx < 0.
- flip_y  output  1  dy < 0.
- flip_identity  output  1  |dy| > |dx|, meaning the axes are swapped.
- last  output  1  the presented point is the ray endpoint.

Behaviour:
- Reset, asynchronous, to IDLE with these values: out_valid=0, x_in=0, y_in=0, flip_x=0, flip_y=0, flip_identity=0, last=0, internal error and counters cleared. cmd_ready=1 while in IDLE, including during reset.
- Reset asserted mid-ray aborts the ray; no further points are emitted.
- States:
  - IDLE -> SETUP on cmd_valid & cmd_ready. dx and dy are captured on that edge.
  - SETUP -> STEP after one cycle, unconditionally.
  - STEP -> IDLE on out_valid & out_ready & last.
- Input saturation in SETUP: dx = -128 is treated as -127, and dy = -64 as -63. This keeps major ≤ 127 and minor ≤ 63, and keeps all negations by the flip stage in range.
- Octant computation in SETUP:
  - ax = |dx|, ay = |dy|.
  - flip_x = dx<0, flip_y = dy<0, flip_identity = ay>ax. A tie (ay == ax) gives flip_identity = 0.
  - major = flip_identity ? ay : ax; minor = flip_identity ? ax : ay.
  - Error term: err = 2*minor - major, held in a signed register of XW+2 bits with no overflow possible.
  - All three flags are registered in SETUP and held constant for the whole ray.
- Stepping in STEP:
  - The first point (0,0) is presented with out_valid=1 in the first STEP cycle, i.e. 2 cycles after command acceptance.
  - On each out_valid & out_ready, if not last: x_in += 1. If err > 0: y_in += 1 and err += 2*(minor - major); otherwise err += 2*minor.
  - last = (x_in == major), registered together with the point.
  - Throughput is 1 point per cycle while out_ready=1.
- Backpressure: while out_valid & !out_ready, x_in, y_in, last and the flags hold stable, and err does not update.
- Point count per ray is exactly major+1, including both ends. The final point is (major, minor).
- Zero-length ray (dx=dy=0): exactly one point (0,0) with last=1 and all flags 0.
- cmd_ready is low in SETUP and STEP. The cycle after the last point's handshake, the block is in IDLE with cmd_ready=1 and out_valid=0.
- The earliest back-to-back command is accepted in the cycle after that handshake.
- cmd_valid outside IDLE is ignored. dx and dy may change freely after acceptance.

Test Plan:
- Reset, then cmd dx=5, dy=2 with out_ready=1:
  - First point 2 cycles after acceptance.
  - Points (0,0),(1,0),(2,1),(3,1),(4,2),(5,2) on consecutive cycles.
  - last only on (5,2); flags 0,0,0; cmd_ready=1 on the following cycle.
- dx=-3, dy=7:
  - flip_x=1, flip_y=0, flip_identity=1.
  - 8 points, x_in 0..7, ending at (7,3) with last=1.
- dx=4, dy=-4 (tie):
  - flip_identity=0, flip_y=1, flip_x=0.
  - Points (k,k) for k=0..4.
- dx=0, dy=0: single point (0,0) with last=1, then IDLE.
- Backpressure on dx=5, dy=2: drop out_ready for 3 cycles while (2,1) is presented -> (2,1) is held unchanged, and the sequence resumes with (3,1) with no point lost or duplicated.
- Saturation and reset:
  - dx=-128, dy=0 -> 128 points, last at x_in=127, flip_x=1.
  - Assert rst asynchronously at point 40 -> out_valid=0 immediately and cmd_ready=1; a new cmd dx=1, dy=1 then runs cleanly with points (0,0),(1,1).
